// File: rtl/conv_pkg.sv
// conv_pkg: shared constants and state type for the 2D convolution datapath
// (Conv plus three bram_memory line buffers) and its memory scheduler.
package conv_pkg;

  localparam int unsigned BIT_LEN    = 8;
  localparam int unsigned CONV_LEN   = 20;
  localparam int unsigned M_LEN      = 3;
  localparam int unsigned NB_ADDRESS = 10;
  localparam int unsigned RAM_WIDTH  = 13;
  localparam int unsigned IMG_LEN    = 441;
  localparam int unsigned CONV_LAT   = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST_C,
    ST_LOAD_K,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/lat_shift.sv
// lat_shift: DEPTH-deep 1-bit delay line.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (priority over shifting)
//   shift_in   : bit entering stage 0 each cycle
//   tap        : oldest stage (DEPTH cycles after entry)
//   all_zero   : no marked bit left anywhere in the line
module lat_shift #(
  parameter int unsigned DEPTH = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic shift_in,
  output logic tap,
  output logic all_zero
);

  logic [DEPTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = clr ? '0 : {sr_q[DEPTH-2:0], shift_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr_q <= '0;
    else        sr_q <= sr_d;
  end

  assign tap      = sr_q[DEPTH-1];
  assign all_zero = (sr_q == '0);

endmodule

// File: rtl/conv_mem_scheduler.sv
// conv_mem_scheduler: frame sequencer for Conv and its line-buffer BRAMs.
// Resets Conv, loads M_LEN kernel columns, streams IMG_LEN read addresses,
// writes results (minus SKIP warm-up ones) back to memory 0, flags done.
//   CLK100MHZ, i_reset      : clock, async active-low reset
//   i_start, i_abort        : frame start pulse, frame cancel
//   i_host_rd_addr          : host read address, routed out in IDLE/DONE
//   o_rd_addr               : BRAM read address (combinational mux)
//   o_wr_addr, o_wr_en      : memory 0 write port
//   o_conv_reset/_valid/_sel_k_i : Conv controls
//   o_busy, o_done          : status
module conv_mem_scheduler
  import conv_pkg::*;
#(
  parameter int unsigned NB_ADDRESS = conv_pkg::NB_ADDRESS,
  parameter int unsigned IMG_LEN    = conv_pkg::IMG_LEN,
  parameter int unsigned M_LEN      = conv_pkg::M_LEN,
  parameter int unsigned CONV_LAT   = conv_pkg::CONV_LAT,
  parameter int unsigned SKIP       = conv_pkg::M_LEN - 1
) (
  input  logic                  CLK100MHZ,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [NB_ADDRESS-1:0] i_host_rd_addr,
  output logic [NB_ADDRESS-1:0] o_rd_addr,
  output logic [NB_ADDRESS-1:0] o_wr_addr,
  output logic                  o_wr_en,
  output logic                  o_conv_reset,
  output logic                  o_conv_valid,
  output logic                  o_conv_sel_k_i,
  output logic                  o_busy,
  output logic                  o_done
);

  state_e                state_q, state_d;
  logic [NB_ADDRESS-1:0] col_cnt_q, col_cnt_d;
  logic [NB_ADDRESS-1:0] rd_cnt_q, rd_cnt_d;
  logic [NB_ADDRESS-1:0] res_cnt_q, res_cnt_d;
  logic [NB_ADDRESS-1:0] wr_addr_q, wr_addr_d;
  logic wr_en_q, wr_en_d;
  logic conv_reset_q, conv_reset_d;
  logic conv_valid_q, conv_valid_d;
  logic sel_q, sel_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic sr_clr, sr_in, tap, all_zero;

  // Marker enters on the edge that issues a read address, and the registered
  // write enable adds one stage, so wr_en lands CONV_LAT cycles after issue.
  lat_shift #(.DEPTH(CONV_LAT)) u_lat (
    .clk      (CLK100MHZ),
    .rst_n    (i_reset),
    .clr      (sr_clr),
    .shift_in (sr_in),
    .tap      (tap),
    .all_zero (all_zero)
  );

  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    res_cnt_d = tap ? res_cnt_q + 1'b1 : res_cnt_q;
    wr_addr_d = wr_en_q ? wr_addr_q + 1'b1 : wr_addr_q;
    sr_clr    = 1'b0;

    unique case (state_q)
      ST_IDLE: if (i_start && !i_abort) state_d = ST_RST_C;
      ST_RST_C: begin
        state_d   = ST_LOAD_K;
        col_cnt_d = '0;
        rd_cnt_d  = '0;
        res_cnt_d = '0;
        wr_addr_d = '0;
        sr_clr    = 1'b1;
      end
      ST_LOAD_K: begin
        col_cnt_d = col_cnt_q + 1'b1;
        if (col_cnt_q == NB_ADDRESS'(M_LEN - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (rd_cnt_q == NB_ADDRESS'(IMG_LEN - 1)) state_d = ST_DRAIN;
        else                                       rd_cnt_d = rd_cnt_q + 1'b1;
      end
      ST_DRAIN: if (all_zero) state_d = ST_DONE;
      ST_DONE:  if (i_start)  state_d = ST_RST_C;
      default:  state_d = ST_IDLE;
    endcase

    if (i_abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      sr_clr  = 1'b1;
    end

    sr_in        = (state_d == ST_RUN);
    wr_en_d      = tap && (res_cnt_q >= NB_ADDRESS'(SKIP)) && (state_d != ST_IDLE);
    conv_reset_d = (state_d == ST_IDLE) || (state_d == ST_RST_C);
    busy_d       = (state_d == ST_LOAD_K) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
    conv_valid_d = busy_d;
    sel_d        = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d       = (state_d == ST_DONE);
  end

  always_ff @(posedge CLK100MHZ or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= ST_IDLE;
      col_cnt_q    <= '0;
      rd_cnt_q     <= '0;
      res_cnt_q    <= '0;
      wr_addr_q    <= '0;
      wr_en_q      <= 1'b0;
      conv_reset_q <= 1'b1;
      conv_valid_q <= 1'b0;
      sel_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_cnt_q    <= col_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      res_cnt_q    <= res_cnt_d;
      wr_addr_q    <= wr_addr_d;
      wr_en_q      <= wr_en_d;
      conv_reset_q <= conv_reset_d;
      conv_valid_q <= conv_valid_d;
      sel_q        <= sel_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign o_rd_addr      = (state_q == ST_IDLE || state_q == ST_DONE) ? i_host_rd_addr : rd_cnt_q;
  assign o_wr_addr      = wr_addr_q;
  assign o_wr_en        = wr_en_q;
  assign o_conv_reset   = conv_reset_q;
  assign o_conv_valid   = conv_valid_q;
  assign o_conv_sel_k_i = sel_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;

endmodule
